// File: rtl/issue_scheduler_pkg.sv
// Shared types and default latencies
// for the issue scheduler slice.
package issue_scheduler_pkg;

  typedef enum logic [1:0] {
    UNIT_INT   = 2'd0,
    UNIT_LD_ST = 2'd1,
    UNIT_MULT  = 2'd2,
    UNIT_DIV   = 2'd3
  } unit_id_t;

  typedef struct packed {
    logic     v;
    unit_id_t unit;
  } cdb_slot_t;

  localparam int DEF_INT_LAT   = 1;
  localparam int DEF_LD_ST_LAT = 2;
  localparam int DEF_MULT_LAT  = 4;
  localparam int DEF_DIV_LAT   = 8;
  localparam int DEF_MAX_LAT   = 8;

endpackage

// File: rtl/issue_scheduler_cdb_rt.sv
// CDB reservation table: one slot per future
// cycle, shifted toward slot 0 every clock.
module cdb_reservation_table
  import issue_scheduler_pkg::*;
#(
  parameter int MAX_LAT = DEF_MAX_LAT,
  parameter int IW      = $clog2(MAX_LAT + 1)
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           book_v,
  input  logic [IW-1:0]  book_idx,
  input  unit_id_t       book_unit,
  output logic [MAX_LAT:0] slot_v,
  output cdb_slot_t      head
);

  cdb_slot_t slot_q [0:MAX_LAT];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k <= MAX_LAT; k++)
        slot_q[k] <= '0;
    end else begin
      for (int k = 0; k < MAX_LAT; k++)
        slot_q[k] <= slot_q[k+1];
      slot_q[MAX_LAT] <= '0;
      if (book_v)
        slot_q[book_idx] <= '{v: 1'b1, unit: book_unit};
    end
  end

  always_comb begin
    slot_v = '0;
    for (int k = 0; k <= MAX_LAT; k++)
      slot_v[k] = slot_q[k].v;
  end

  assign head = slot_q[0];

endmodule

// File: rtl/issue_scheduler.sv
// Single-issue round-robin scheduler that books
// the CDB cycle of each grant and tracks the divider.
module issue_scheduler
  import issue_scheduler_pkg::*;
#(
  parameter int INT_LAT   = DEF_INT_LAT,
  parameter int LD_ST_LAT = DEF_LD_ST_LAT,
  parameter int MULT_LAT  = DEF_MULT_LAT,
  parameter int DIV_LAT   = DEF_DIV_LAT,
  parameter int MAX_LAT   = DEF_MAX_LAT
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       int_ready,
  input  logic       ld_st_ready,
  input  logic       mult_ready,
  input  logic       div_ready,
  input  logic       flush,
  output logic       int_rd,
  output logic       ld_st_rd,
  output logic       mult_rd,
  output logic       div_rd,
  output logic       div_busy,
  output logic       cdb_owner_valid,
  output logic [1:0] cdb_owner
);

  localparam int IW = $clog2(MAX_LAT + 1);
  localparam int CW = $clog2(DIV_LAT) + 1;

  logic [MAX_LAT:0] slot_v;
  cdb_slot_t        head;
  logic [3:0]       elig;
  logic [3:0]       grant;
  logic [1:0]       ptr_q;
  logic [1:0]       idx;
  logic [CW-1:0]    div_cnt_q;
  logic             g_v;
  unit_id_t         g_unit;
  logic [IW-1:0]    book_idx;
  logic             ok;
  logic             unused;

  assign unused = ^slot_v;
  assign ok     = ~flush & ~i_rst;

  assign elig[0] = int_ready & ~slot_v[INT_LAT] & ok;
  assign elig[1] = ld_st_ready & ~slot_v[LD_ST_LAT] & ok;
  assign elig[2] = mult_ready & ~slot_v[MULT_LAT] & ok;
  assign elig[3] = div_ready & ~slot_v[DIV_LAT] & ok
                 & (div_cnt_q == '0);

  always_comb begin
    g_v    = 1'b0;
    g_unit = UNIT_INT;
    idx    = ptr_q;
    for (int i = 0; i < 4; i++) begin
      idx = ptr_q + i[1:0];
      if (!g_v && elig[idx]) begin
        g_v    = 1'b1;
        g_unit = unit_id_t'(idx);
      end
    end
  end

  assign grant = g_v ? (4'b0001 << g_unit) : 4'b0000;

  always_comb begin
    book_idx = '0;
    unique case (g_unit)
      UNIT_INT:   book_idx = IW'(INT_LAT - 1);
      UNIT_LD_ST: book_idx = IW'(LD_ST_LAT - 1);
      UNIT_MULT:  book_idx = IW'(MULT_LAT - 1);
      UNIT_DIV:   book_idx = IW'(DIV_LAT - 1);
    endcase
  end

  cdb_reservation_table #(
    .MAX_LAT (MAX_LAT),
    .IW      (IW)
  ) u_rt (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .book_v    (g_v),
    .book_idx  (book_idx),
    .book_unit (g_unit),
    .slot_v    (slot_v),
    .head      (head)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ptr_q     <= 2'd0;
      div_cnt_q <= '0;
    end else begin
      if (g_v)
        ptr_q <= 2'(g_unit) + 2'd1;
      if (grant[3])
        div_cnt_q <= CW'(DIV_LAT - 1);
      else if (div_cnt_q != '0)
        div_cnt_q <= div_cnt_q - 1'b1;
    end
  end

  assign int_rd          = grant[0];
  assign ld_st_rd        = grant[1];
  assign mult_rd         = grant[2];
  assign div_rd          = grant[3];
  assign div_busy        = (div_cnt_q != '0) & ~i_rst;
  assign cdb_owner_valid = head.v & ~i_rst;
  assign cdb_owner       = cdb_owner_valid ? head.unit : 2'd0;

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed-vector bench for issue_scheduler
// with hand-computed grant and CDB expectations.
module tb_issue_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       int_ready, ld_st_ready, mult_ready, div_ready;
  logic       flush;
  logic       int_rd, ld_st_rd, mult_rd, div_rd;
  logic       div_busy, cdb_owner_valid;
  logic [1:0] cdb_owner;
  logic [3:0] rd;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign rd = {div_rd, mult_rd, ld_st_rd, int_rd};

  issue_scheduler dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .int_ready       (int_ready),
    .ld_st_ready     (ld_st_ready),
    .mult_ready      (mult_ready),
    .div_ready       (div_ready),
    .flush           (flush),
    .int_rd          (int_rd),
    .ld_st_rd        (ld_st_rd),
    .mult_rd         (mult_rd),
    .div_rd          (div_rd),
    .div_busy        (div_busy),
    .cdb_owner_valid (cdb_owner_valid),
    .cdb_owner       (cdb_owner)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // rdy = {div, mult, ld_st, int}
  task automatic drive(input logic [3:0] rdy,
                       input logic fl,
                       input logic rs);
    @(posedge clk);
    #1;
    {div_ready, mult_ready, ld_st_ready, int_ready} = rdy;
    flush = fl;
    rst   = rs;
    @(negedge clk);
  endtask

  task automatic cdb(input string tag,
                     input logic v,
                     input logic [1:0] o);
    check({tag, "_v"}, 32'(cdb_owner_valid), 32'(v));
    check({tag, "_o"}, 32'(cdb_owner), 32'(o));
  endtask

  task automatic do_reset();
    drive(4'h0, 1'b0, 1'b1);
    drive(4'h0, 1'b0, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    {div_ready, mult_ready, ld_st_ready, int_ready} = 4'h0;

    // reset with all ready
    drive(4'hf, 1'b0, 1'b1);
    drive(4'hf, 1'b0, 1'b1);
    check("rst_rd", 32'(rd), 32'h0);
    check("rst_busy", 32'(div_busy), 32'h0);
    cdb("rst_cdb", 1'b0, 2'd0);
    drive(4'hf, 1'b0, 1'b0);
    check("rel_rd", 32'(rd), 32'h1);
    drive(4'h0, 1'b0, 1'b0);
    check("rel_rd1", 32'(rd), 32'h0);
    cdb("rel_cdb", 1'b1, 2'd0);

    // all ready continuously
    do_reset();
    for (int t = 0; t < 12; t++) begin
      logic [3:0] er [5];
      er = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
      drive(4'hf, 1'b0, 1'b0);
      if (t <= 4)
        check($sformatf("rr_rd_t%0d", t), 32'(rd), 32'(er[t]));
      case (t)
        1: cdb("rr_t1", 1'b1, 2'd0);
        2: cdb("rr_t2", 1'b0, 2'd0);
        3: cdb("rr_t3", 1'b1, 2'd1);
        4: cdb("rr_t4", 1'b0, 2'd0);
        5: cdb("rr_t5", 1'b1, 2'd0);
        6: cdb("rr_t6", 1'b1, 2'd2);
        11: cdb("rr_t11", 1'b1, 2'd3);
        default: ;
      endcase
    end

    // CDB conflict
    do_reset();
    drive(4'h4, 1'b0, 1'b0);
    check("cf_t0", 32'(rd), 32'h4);
    drive(4'h0, 1'b0, 1'b0);
    drive(4'h2, 1'b0, 1'b0);
    check("cf_t2", 32'(rd), 32'h0);
    drive(4'h2, 1'b0, 1'b0);
    check("cf_t3", 32'(rd), 32'h2);
    drive(4'h0, 1'b0, 1'b0);
    cdb("cf_t4", 1'b1, 2'd2);
    drive(4'h0, 1'b0, 1'b0);
    cdb("cf_t5", 1'b1, 2'd1);

    // divider occupancy
    do_reset();
    drive(4'h8, 1'b0, 1'b0);
    check("dv_t0", 32'(rd), 32'h8);
    check("dv_busy0", 32'(div_busy), 32'h0);
    for (int t = 1; t <= 16; t++) begin
      drive((t <= 8) ? 4'h8 : 4'h0, 1'b0, 1'b0);
      if (t <= 7) begin
        check($sformatf("dv_busy_t%0d", t),
              32'(div_busy), 32'h1);
        check($sformatf("dv_rd_t%0d", t), 32'(rd), 32'h0);
      end
      if (t == 8) begin
        check("dv_rd_t8", 32'(rd), 32'h8);
        check("dv_busy_t8", 32'(div_busy), 32'h0);
        cdb("dv_t8", 1'b1, 2'd3);
      end
      if (t == 16) cdb("dv_t16", 1'b1, 2'd3);
    end

    // flush
    do_reset();
    drive(4'h4, 1'b0, 1'b0);
    check("fl_t0", 32'(rd), 32'h4);
    drive(4'hf, 1'b1, 1'b0);
    check("fl_t1", 32'(rd), 32'h0);
    drive(4'h0, 1'b0, 1'b0);
    drive(4'h0, 1'b0, 1'b0);
    drive(4'h0, 1'b0, 1'b0);
    cdb("fl_t4", 1'b1, 2'd2);

    // reset mid-operation
    do_reset();
    drive(4'h4, 1'b0, 1'b0);
    check("mr_t0", 32'(rd), 32'h4);
    drive(4'h8, 1'b0, 1'b0);
    check("mr_t1", 32'(rd), 32'h8);
    drive(4'hf, 1'b0, 1'b1);
    check("mr_t2", 32'(rd), 32'h0);
    check("mr_busy2", 32'(div_busy), 32'h0);
    cdb("mr_t2", 1'b0, 2'd0);
    drive(4'h0, 1'b0, 1'b0);
    check("mr_busy3", 32'(div_busy), 32'h0);
    drive(4'h0, 1'b0, 1'b0);
    cdb("mr_t4", 1'b0, 2'd0);
    drive(4'hf, 1'b0, 1'b0);
    check("mr_t5", 32'(rd), 32'h1);
    drive(4'h0, 1'b0, 1'b0);
    cdb("mr_t6", 1'b1, 2'd0);
    drive(4'h0, 1'b0, 1'b0);
    drive(4'h0, 1'b0, 1'b0);
    drive(4'h0, 1'b0, 1'b0);
    cdb("mr_t9", 1'b0, 2'd0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
